// File: rtl/count_event_monitor_pkg.sv
// ---------------------------------------------------------------------------
// count_mon_pkg
// Shared types and default sizes for the count_event_monitor slice.
//   mon_state_t  : matcher FSM states (IDLE / ARMED / HIT)
//   step_class_t : classification of one counter step
//   DEF_WIDTH    : default width of the monitored counter value
//   DEF_WRAP_W   : default width of the saturating wrap counter
// ---------------------------------------------------------------------------
package count_mon_pkg;

  localparam int DEF_WIDTH  = 32'd4;
  localparam int DEF_WRAP_W = 32'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIT   = 2'd2
  } mon_state_t;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2,
    STEP_ILL  = 2'd3
  } step_class_t;

endpackage

// File: rtl/count_event_monitor_if.sv
// ---------------------------------------------------------------------------
// count_event_monitor_if
// Valid/ready match-event channel leaving the monitor.
//   evt_valid : match event pending (producer -> consumer)
//   evt_ready : consumer accepts the event (consumer -> producer)
//   evt_q     : counter value captured at the match
// Modports: master = event producer (the monitor), slave = event consumer.
// ---------------------------------------------------------------------------
interface count_event_monitor_if #(
  parameter int WIDTH = 32'd4
);
  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_q;

  modport master (output evt_valid, output evt_q, input evt_ready);
  modport slave  (input evt_valid, input evt_q, output evt_ready);
endinterface

// File: rtl/count_event_monitor_step_detect.sv
// ---------------------------------------------------------------------------
// count_step_detect
// Purely combinational classification of one counter step.
//   q_in       : current counter value
//   q_d        : counter value sampled on the previous clock
//   primed     : 0 during the first cycle after reset (q_d not yet valid)
//   step_class : HOLD / INC / DEC / ILL
//   wrap       : legal step crossing the all-ones/zero boundary
// Build option: COUNT_DOWN_EN makes a decrement legal (0 -> all-ones wraps).
// ---------------------------------------------------------------------------
module count_step_detect
  import count_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] q_d,
  input  logic             primed,
  output step_class_t      step_class,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] delta_s;

  // Modular difference between samples decides the step class
  always_comb begin
    delta_s    = q_in - q_d;
    step_class = STEP_HOLD;
    wrap       = 1'b0;
    if (!primed) begin
      // q_d still holds the reset value, so nothing is classified yet
      step_class = STEP_HOLD;
      wrap       = 1'b0;
    end else if (delta_s == ZERO) begin
      step_class = STEP_HOLD;
      wrap       = 1'b0;
    end else if (delta_s == ONE) begin
      step_class = STEP_INC;
      wrap       = (q_d == ONES);
`ifdef COUNT_DOWN_EN
    end else if (delta_s == ONES) begin
      step_class = STEP_DEC;
      wrap       = (q_d == ZERO);
`endif
    end else begin
      step_class = STEP_ILL;
      wrap       = 1'b0;
    end
  end

endmodule

// File: rtl/count_event_monitor.sv
// ---------------------------------------------------------------------------
// count_event_monitor
// Supervises a WIDTH-bit counter: classifies every step, counts wraps into a
// saturating extension counter, flags illegal steps and raises a handshaked
// event when an armed {wraps, q} target is reached.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   q_in                : monitored counter value
//   clr_stat            : clears wrap_cnt, wrap_ovf, err_sticky
//   arm / cancel        : arm (latching tgt_q, tgt_wraps) / disarm the matcher
//   tgt_q, tgt_wraps    : match target (wraps counted relative to arm time)
//   tc                  : previous sample was all-ones
//   wrap_pulse          : one-cycle pulse per legal wrap
//   wrap_cnt, wrap_ovf  : saturating wrap count, sticky overflow
//   err_pulse/err_sticky: illegal-step pulse and sticky flag
//   armed               : matcher waiting for its target
//   evt                 : valid/ready event channel (master side)
//   dir_down            : only with COUNT_DOWN_EN; last non-hold step was down
// Build option: COUNT_DOWN_EN (decrements legal, adds dir_down).
// ---------------------------------------------------------------------------
module count_event_monitor
  import count_mon_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WRAP_W = DEF_WRAP_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     q_in,
  input  logic                 clr_stat,
  input  logic                 arm,
  input  logic                 cancel,
  input  logic [WIDTH-1:0]     tgt_q,
  input  logic [WRAP_W-1:0]    tgt_wraps,
  output logic                 tc,
  output logic                 wrap_pulse,
  output logic [WRAP_W-1:0]    wrap_cnt,
  output logic                 wrap_ovf,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic                 armed,
  count_event_monitor_if.master evt
`ifdef COUNT_DOWN_EN
  ,
  output logic                 dir_down
`endif
);

  localparam logic [WIDTH-1:0]  Q_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  Q_ONES   = {WIDTH{1'b1}};
  localparam logic [WRAP_W-1:0] W_ZERO   = {WRAP_W{1'b0}};
  localparam logic [WRAP_W-1:0] W_ONE    = {{(WRAP_W-1){1'b0}}, 1'b1};
  localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

  // Sampling / statistics registers
  logic [WIDTH-1:0]  samp_q, samp_d;
  logic              primed_q, primed_d;
  logic              tc_q, tc_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              wrap_ovf_q, wrap_ovf_d;
  logic              err_pulse_q, err_pulse_d;
  logic              err_sticky_q, err_sticky_d;

  // Matcher registers
  mon_state_t        state_q, state_d;
  logic [WRAP_W-1:0] arm_wraps_q, arm_wraps_d;
  logic [WIDTH-1:0]  tgt_val_q, tgt_val_d;
  logic [WRAP_W-1:0] tgt_wraps_q, tgt_wraps_d;
  logic              armed_q, armed_d;
  logic              evt_valid_q, evt_valid_d;
  logic [WIDTH-1:0]  evt_data_q, evt_data_d;

  // Combinational helpers
  step_class_t       step_class_s;
  logic              wrap_s;
  logic              ill_s;
  logic [WRAP_W-1:0] arm_wraps_inc_s;
  logic              match_s;
  logic              arm_accept_s;
  logic              hit_entry_s;
  logic              handshake_s;

  count_step_detect #(.WIDTH(WIDTH)) u_step (
    .q_in       (q_in),
    .q_d        (samp_q),
    .primed     (primed_q),
    .step_class (step_class_s),
    .wrap       (wrap_s)
  );

  assign ill_s = (step_class_s == STEP_ILL);

  // Next values of the sample, pulse and statistics registers
  always_comb begin
    samp_d       = q_in;
    primed_d     = 1'b1;
    tc_d         = (q_in == Q_ONES);
    wrap_pulse_d = wrap_s;
    err_pulse_d  = ill_s;
    wrap_cnt_d   = wrap_cnt_q;
    wrap_ovf_d   = wrap_ovf_q;
    err_sticky_d = err_sticky_q;
    if (clr_stat) begin
      // a wrap in the same cycle is deliberately lost
      wrap_cnt_d   = W_ZERO;
      wrap_ovf_d   = 1'b0;
      err_sticky_d = 1'b0;
    end else begin
      if (wrap_s) begin
        if (wrap_cnt_q == WRAP_MAX) begin
          wrap_ovf_d = 1'b1;
        end else begin
          wrap_cnt_d = wrap_cnt_q + W_ONE;
        end
      end else begin
        wrap_cnt_d = wrap_cnt_q;
      end
      if (ill_s) begin
        err_sticky_d = 1'b1;
      end else begin
        err_sticky_d = err_sticky_q;
      end
    end
  end

  // Sample, pulse and statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q       <= Q_ZERO;
      primed_q     <= 1'b0;
      tc_q         <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= W_ZERO;
      wrap_ovf_q   <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      samp_q       <= samp_d;
      primed_q     <= primed_d;
      tc_q         <= tc_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
      wrap_ovf_q   <= wrap_ovf_d;
      err_pulse_q  <= err_pulse_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Match compare sees arm_wraps already bumped by a wrap in this cycle
  assign arm_wraps_inc_s = (wrap_s && (arm_wraps_q != WRAP_MAX)) ? (arm_wraps_q + W_ONE)
                                                                  : arm_wraps_q;
  assign match_s     = (q_in == tgt_val_q) && (arm_wraps_inc_s == tgt_wraps_q) && primed_q;
  assign handshake_s = evt_valid_q && evt.evt_ready;

  // Matcher next-state logic: cancel beats arm, arm beats a match
  always_comb begin
    state_d      = state_q;
    arm_accept_s = 1'b0;
    hit_entry_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d      = ARMED;
          arm_accept_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (arm) begin
          state_d      = ARMED;
          arm_accept_s = 1'b1;
        end else if (match_s) begin
          state_d     = HIT;
          hit_entry_s = 1'b1;
        end else begin
          state_d = ARMED;
        end
      end
      HIT: begin
        if (handshake_s) begin
          state_d = IDLE;
        end else begin
          state_d = HIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Matcher outputs and target/arm_wraps datapath
  always_comb begin
    tgt_val_d   = tgt_val_q;
    tgt_wraps_d = tgt_wraps_q;
    arm_wraps_d = arm_wraps_q;
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    armed_d     = (state_d == ARMED);
    if (arm_accept_s) begin
      tgt_val_d   = tgt_q;
      tgt_wraps_d = tgt_wraps;
      arm_wraps_d = W_ZERO;
    end else if (state_q == ARMED) begin
      arm_wraps_d = arm_wraps_inc_s;
    end else begin
      arm_wraps_d = arm_wraps_q;
    end
    if (hit_entry_s) begin
      evt_valid_d = 1'b1;
      evt_data_d  = q_in;
    end else if (handshake_s) begin
      evt_valid_d = 1'b0;
    end else begin
      evt_valid_d = evt_valid_q;
    end
  end

  // Matcher state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      arm_wraps_q <= W_ZERO;
      tgt_val_q   <= Q_ZERO;
      tgt_wraps_q <= W_ZERO;
      armed_q     <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= Q_ZERO;
    end else begin
      state_q     <= state_d;
      arm_wraps_q <= arm_wraps_d;
      tgt_val_q   <= tgt_val_d;
      tgt_wraps_q <= tgt_wraps_d;
      armed_q     <= armed_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
    end
  end

`ifdef COUNT_DOWN_EN
  logic dir_down_q, dir_down_d;

  // Direction remembers the last non-hold legal step
  always_comb begin
    if (step_class_s == STEP_DEC) begin
      dir_down_d = 1'b1;
    end else if (step_class_s == STEP_INC) begin
      dir_down_d = 1'b0;
    end else begin
      dir_down_d = dir_down_q;
    end
  end

  // Direction register
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_down_q <= 1'b0;
    end else begin
      dir_down_q <= dir_down_d;
    end
  end

  assign dir_down = dir_down_q;
`endif

  assign tc            = tc_q;
  assign wrap_pulse    = wrap_pulse_q;
  assign wrap_cnt      = wrap_cnt_q;
  assign wrap_ovf      = wrap_ovf_q;
  assign err_pulse     = err_pulse_q;
  assign err_sticky    = err_sticky_q;
  assign armed         = armed_q;
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_q     = evt_data_q;

endmodule

// File: tb/tb_count_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_count_event_monitor
// Randomised + directed stimulus against an arithmetic reference model.
// The driver pushes the expected post-edge outputs into a queue; a monitor
// pops one entry per clock and compares; a second queue tracks expected
// event payloads, popped whenever the DUT raises evt_valid.
// DUT is built with WRAP_W=2 so wrap saturation is reached quickly.
// ---------------------------------------------------------------------------
module tb_count_event_monitor;

  localparam int W    = 4;
  localparam int WW   = 2;
  localparam int QMOD = 16;
  localparam int WMAX = 3;

  logic          clk = 1'b0;
  logic          reset, clr_stat, arm, cancel;
  logic [W-1:0]  q_in, tgt_q;
  logic [WW-1:0] tgt_wraps;
  logic          tc, wrap_pulse, wrap_ovf, err_pulse, err_sticky, armed;
  logic [WW-1:0] wrap_cnt;
`ifdef COUNT_DOWN_EN
  logic          dir_down;
`endif

  always #5 clk = ~clk;

  count_event_monitor_if #(.WIDTH(W)) evt_if ();

  count_event_monitor #(.WIDTH(W), .WRAP_W(WW)) dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .clr_stat   (clr_stat),
    .arm        (arm),
    .cancel     (cancel),
    .tgt_q      (tgt_q),
    .tgt_wraps  (tgt_wraps),
    .tc         (tc),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt),
    .wrap_ovf   (wrap_ovf),
    .err_pulse  (err_pulse),
    .err_sticky (err_sticky),
    .armed      (armed),
    .evt        (evt_if.master)
`ifdef COUNT_DOWN_EN
    ,
    .dir_down   (dir_down)
`endif
  );

  typedef struct {
    int tc; int wp; int wc; int wo; int ep; int es; int ar; int ev; int eq; int dd;
  } exp_t;

  exp_t exp_q[$];
  int   evq_q[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model state: mode 0 = idle, 1 = waiting for target, 2 = event pending
  int m_prev, m_primed, m_wraps, m_ovf, m_err, m_mode, m_aw, m_tq, m_tw, m_evq, m_dir;
  int cq;
  bit g_rdy = 1'b1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model(input bit rst, input int qv, input bit clr, input bit a, input bit c,
                       input int tq, input int tw, input bit rdy);
    exp_t e;
    int delta, wrap, ill, aw_now;
    if (rst) begin
      m_prev = 0; m_primed = 0; m_wraps = 0; m_ovf = 0; m_err = 0; m_mode = 0;
      m_aw = 0; m_tq = 0; m_tw = 0; m_evq = 0; m_dir = 0;
      e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    end else begin
      delta = (qv - m_prev + QMOD) % QMOD;
      wrap = 0; ill = 0;
      if (m_primed != 0) begin
        if (delta == 1) begin
          wrap = (m_prev == QMOD - 1) ? 1 : 0;
          m_dir = 0;
`ifdef COUNT_DOWN_EN
        end else if (delta == QMOD - 1) begin
          wrap = (m_prev == 0) ? 1 : 0;
          m_dir = 1;
`endif
        end else if (delta != 0) begin
          ill = 1;
        end
      end
      aw_now = (m_aw + wrap > WMAX) ? WMAX : m_aw + wrap;
      case (m_mode)
        0: if (a) begin m_mode = 1; m_tq = tq; m_tw = tw; m_aw = 0; end
        1: begin
          if (c) m_mode = 0;
          else if (a) begin m_tq = tq; m_tw = tw; m_aw = 0; end
          else if (qv == m_tq && aw_now == m_tw && m_primed != 0) begin
            m_mode = 2; m_evq = qv; evq_q.push_back(qv); m_aw = aw_now;
          end else m_aw = aw_now;
        end
        default: if (rdy) m_mode = 0;
      endcase
      if (clr) begin
        m_wraps = 0; m_ovf = 0; m_err = 0;
      end else begin
        if (wrap != 0) begin
          if (m_wraps == WMAX) m_ovf = 1; else m_wraps++;
        end
        if (ill != 0) m_err = 1;
      end
      m_prev = qv; m_primed = 1;
      e.tc = (qv == QMOD - 1) ? 1 : 0; e.wp = wrap; e.wc = m_wraps; e.wo = m_ovf;
      e.ep = ill; e.es = m_err; e.ar = (m_mode == 1) ? 1 : 0; e.ev = (m_mode == 2) ? 1 : 0;
      e.eq = m_evq; e.dd = m_dir;
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rst, input int qv, input bit clr, input bit a, input bit c,
                     input int tq, input int tw, input bit rdy);
    @(negedge clk);
    reset = rst; q_in = qv[W-1:0]; clr_stat = clr; arm = a; cancel = c;
    tgt_q = tq[W-1:0]; tgt_wraps = tw[WW-1:0]; evt_if.evt_ready = rdy;
    model(rst, qv, clr, a, c, tq, tw, rdy);
    cq = qv;
  endtask

  task automatic tick(input int qv);
    cyc(1'b0, qv, 1'b0, 1'b0, 1'b0, 0, 0, g_rdy);
  endtask

  task automatic inc_n(input int n);
    for (int i = 0; i < n; i++) tick((cq + 1) % QMOD);
  endtask

  // monitor: one expected snapshot per clock, plus event payload scoreboard
  initial begin
    exp_t e;
    bit prev_ev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tc", int'(tc), e.tc);
        chk("wrap_pulse", int'(wrap_pulse), e.wp);
        chk("wrap_cnt", int'(wrap_cnt), e.wc);
        chk("wrap_ovf", int'(wrap_ovf), e.wo);
        chk("err_pulse", int'(err_pulse), e.ep);
        chk("err_sticky", int'(err_sticky), e.es);
        chk("armed", int'(armed), e.ar);
        chk("evt_valid", int'(evt_if.evt_valid), e.ev);
        chk("evt_q", int'(evt_if.evt_q), e.eq);
`ifdef COUNT_DOWN_EN
        chk("dir_down", int'(dir_down), e.dd);
`endif
      end
      if (evt_if.evt_valid && !prev_ev) begin
        if (evq_q.size() == 0) chk("evt_unexpected", 1, 0);
        else chk("evt_payload", int'(evt_if.evt_q), evq_q.pop_front());
      end
      prev_ev = evt_if.evt_valid;
    end
  end

  initial begin
    int r;
    bit c_clr, c_arm, c_can, c_rst;
    reset = 1'b1; q_in = '0; clr_stat = 1'b0; arm = 1'b0; cancel = 1'b0;
    tgt_q = '0; tgt_wraps = '0; evt_if.evt_ready = 1'b1;

    // reset, then a full ramp with one wrap
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < 16; i++) tick(i);
    tick(0); tick(1);

    // illegal 3 -> 7 jump, then clear the sticky flag
    tick(2); tick(3); tick(7); tick(7);
    cyc(1'b0, 7, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    tick(8);

    // four more wraps saturate the 2-bit counter, then a wrap lost to clr_stat
    inc_n(64);
    while (cq != 15) inc_n(1);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
    tick(1);

    // arm at q=2 for {1 wrap, q=5}; consumer stalls, then accepts
    tick(2);
    cyc(1'b0, 2, 1'b0, 1'b1, 1'b0, 5, 1, 1'b1);
    g_rdy = 1'b0;
    inc_n(19);
    tick(5); tick(5); tick(5);
    g_rdy = 1'b1;
    tick(5); tick(5);

    // arm, then cancel exactly when the target value appears
    cyc(1'b0, 5, 1'b0, 1'b1, 1'b0, 7, 0, 1'b1);
    tick(6);
    cyc(1'b0, 7, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    tick(8);

    // arm while q already equals the target: match one cycle later
    cyc(1'b0, 9, 1'b0, 1'b1, 1'b0, 9, 0, 1'b1);
    tick(9); tick(9);

    // down-step across zero
    while (cq != 1) inc_n(1);
    tick(0); tick(15); tick(15);

    // randomised traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      c_rst = ($urandom_range(0, 199) == 0);
      c_clr = ($urandom_range(0, 99) < 3);
      c_arm = ($urandom_range(0, 99) < 6);
      c_can = ($urandom_range(0, 99) < 3);
      if (r < 70)      cq = (cq + 1) % QMOD;
      else if (r < 80) cq = cq;
      else if (r < 90) cq = (cq + QMOD - 1) % QMOD;
      else             cq = $urandom_range(0, QMOD - 1);
      cyc(c_rst, cq, c_clr, c_arm, c_can, $urandom_range(0, QMOD - 1),
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, WMAX) : $urandom_range(0, 1),
          ($urandom_range(0, 99) < 60));
    end

    tick(cq); tick(cq);
    @(posedge clk);
    #2;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("evt_queue_drained", evq_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
- Downstream consumer of the 4-bit synchronous JK counter.
- Samples the counter's q bus every clock and classifies each step as hold, increment or illegal skip.
- Counts counter wrap-arounds (15->0) into an extended wrap counter.
- Raises a handshaked match event when an armed {wraps, q} target is reached; gives the counter a cycle-accurate supervisor and a coarse extension of its range.

Parameters:
- WIDTH, 4, width of the monitored counter value.
- WRAP_W, 8, width of the wrap counter; saturates at 2^WRAP_W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- q_in  input  WIDTH  counter value, driven from the counter's q outputs.
- clr_stat  input  1  one-cycle pulse; clears wrap_cnt, wrap_ovf and err_sticky.
- arm  input  1  one-cycle pulse; latches the target and arms the matcher.
- cancel  input  1  one-cycle pulse; disarms the matcher.
- tgt_q  input  WIDTH  target counter value, latched on arm.
- tgt_wraps  input  WRAP_W  target wrap count relative to arm time, latched on arm.
- tc  output  1  q_d equals all-ones (terminal count).
- wrap_pulse  output  1  one-cycle pulse on each legal wrap.
- wrap_cnt  output  WRAP_W  saturating wrap count.
- wrap_ovf  output  1  sticky; set when a wrap occurs while wrap_cnt is saturated.
- err_pulse  output  1  one-cycle pulse on an illegal step.
- err_sticky  output  1  sticky illegal-step flag.
- armed  output  1  matcher is in state ARMED.
- evt_valid  output  1  match event pending.
- evt_ready  input  1  consumer accepts the event.
- evt_q  output  WIDTH  q value captured at the match.

Behaviour:
- Reset (synchronous): all outputs 0; q_d=0; primed=0; FSM=IDLE.
- Sampling:
  - q_d <= q_in every cycle.
  - The first cycle after reset only primes: primed goes to 1, and no step, wrap or error events fire.
- Step classification, combinational on q_in vs q_d, registered into the outputs, so latency is 1 cycle from the q_in edge:
  - delta = (q_in - q_d) mod 2^WIDTH.
  - delta 0: hold.
  - delta 1: increment; a wrap when q_d=all-ones and q_in=0.
  - any other delta: illegal. err_pulse=1 and err_sticky set; wrap_cnt is unchanged even if q_in=0.
- wrap_cnt:
  - Increments on each wrap.
  - At 2^WRAP_W-1 it holds and sets wrap_ovf.
- tc is registered-path only: tc = (q_d == all-ones).
- Priority in one cycle: reset > clr_stat > wrap/err update.
  - A wrap coincident with clr_stat is discarded, leaving wrap_cnt=0.
  - err_pulse still fires even when clr_stat is asserted.
- Matcher FSM, states IDLE, ARMED, HIT:
  - Separate arm_wraps counter: cleared on arm, increments (saturating) on each wrap while ARMED.
  - IDLE --arm--> ARMED: latch tgt_q and tgt_wraps.
  - ARMED --cancel--> IDLE; cancel has priority over a same-cycle match.
  - ARMED --(q_in==tgt_q && arm_wraps==tgt_wraps && primed)--> HIT.
    - Compare uses the arm_wraps value including a same-cycle wrap.
    - evt_valid=1 and evt_q=q_in are registered on entry.
  - HIT: evt_valid and evt_q are held until the evt_valid && evt_ready cycle, then -> IDLE with evt_valid=0 the next cycle.
  - arm in ARMED re-latches the target and clears arm_wraps.
  - arm and cancel in HIT are ignored.
  - arm in the same cycle as the handshake is ignored.
  - arm in IDLE when q_in already equals tgt_q with tgt_wraps=0 matches one cycle later, while ARMED.
- An illegal step does not affect the FSM.
- armed = (state==ARMED).

Optional Feature:
- Macro COUNT_DOWN_EN.
- Defined:
  - delta = 2^WIDTH-1 (decrement) is legal.
  - 0->all-ones counts as an underflow wrap: it increments wrap_cnt and pulses wrap_pulse.
  - Adds output dir_down (1 bit, reset 0), registered, set on the last non-hold step direction.
- Undefined: a decrement is an illegal step, and the dir_down port is absent.

Decomposition:
- Package count_mon_pkg holds:
  - enum mon_state_t {IDLE, ARMED, HIT};
  - step-class enum {STEP_HOLD, STEP_INC, STEP_DEC, STEP_ILL};
  - default WIDTH/WRAP_W constants.
- Sub-module count_step_detect: takes q_in, q_d and primed; returns the step class and the wrap flag. This is combinational classification only.
- FSM, counters and sticky flags stay in the top level.

Test Plan:
- Reset, then q_in ramps 0..15,0,1 -> tc=1 for the cycle after q_d=15; one wrap_pulse; wrap_cnt=1; err_sticky=0.
- q_in steps 3->7 -> err_pulse one cycle, err_sticky=1, wrap_cnt unchanged; clr_stat -> err_sticky=0.
- WRAP_W=2, run 4 wraps -> wrap_cnt stays 3, wrap_ovf=1; wrap coincident with clr_stat -> wrap_cnt=0.
- arm with tgt_q=5, tgt_wraps=1 at q=2 -> evt_valid rises after 15->0->...->5; evt_q=5; hold evt_ready=0 for 3 cycles -> evt_valid stays 1; ready -> IDLE.
- arm, then cancel in the same cycle q_in==tgt_q -> no event, armed=0.
- COUNT_DOWN_EN: q_in 1,0,15 -> no error, wrap_cnt=1, dir_down=1; without the macro -> err_pulse on 0->15.
